// File: rtl/nor_truth_table_sequencer.sv
// Stimulus/checker stage for the two-input NOR block and its structural twin.
// Walks the operand bus through every minterm in ascending order, lets each
// minterm settle for SETTLE idle cycles, samples dut_s and scores it against
// the EXPECTED truth table. A sweep ends with a one-cycle done pulse together
// with pass, a per-minterm failure mask and a mismatch count.
module nor_truth_table_sequencer #(
    parameter int                N        = 2,
    parameter logic [2**N-1:0]   EXPECTED = 4'b0001,
    parameter int                SETTLE   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dut_s,
    output logic [N-1:0]      operands,
    output logic [N-1:0]      minterm_idx,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2**N-1:0]   fail_mask,
    output logic [N:0]        mismatch_count
);

    localparam logic [3:0]   SETTLE_C = 4'(SETTLE);
    localparam logic [N-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [N-1:0]      idx, idx_n;
    logic [3:0]        wait_cnt, wait_n;
    logic [2**N-1:0]   mask_n;
    logic [N:0]        cnt_n;
    logic              pass_n;
    logic              done_n;
    logic              busy_n;
    logic [N-1:0]      ops_n;

    // X/Z on the DUT output must score as a mismatch, so the case-inequality
    // operator is used rather than the logical one.
    function automatic logic is_mismatch(input logic observed, input logic required);
        return (observed !== required);
    endfunction

    // The count is N+1 bits wide and at most 2^N minterms are scored per
    // sweep, so a plain increment can never wrap.
    function automatic logic [N:0] count_inc(input logic [N:0] cnt);
        return cnt + (N+1)'(1);
    endfunction

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        wait_n  = wait_cnt;
        mask_n  = fail_mask;
        cnt_n   = mismatch_count;
        pass_n  = pass;
        done_n  = 1'b0;
        busy_n  = 1'b0;
        ops_n   = '0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    // A new sweep starts from a clean scoreboard, directly
                    // from DONE when start is already waiting.
                    state_n = RUN;
                    idx_n   = '0;
                    wait_n  = '0;
                    mask_n  = '0;
                    cnt_n   = '0;
                    pass_n  = 1'b0;
                    busy_n  = 1'b1;
                    ops_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end

            RUN: begin
                busy_n = 1'b1;
                ops_n  = idx;
                if (wait_cnt == SETTLE_C) begin
                    if (is_mismatch(dut_s, EXPECTED[idx])) begin
                        mask_n[idx] = 1'b1;
                        cnt_n       = count_inc(mismatch_count);
                    end
                    if (idx == IDX_LAST) begin
                        // Terminal minterm: the verdict already includes
                        // this last sample when done is raised.
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        pass_n  = (cnt_n == '0);
                        ops_n   = '0;
                    end else begin
                        idx_n  = idx + N'(1);
                        wait_n = '0;
                        ops_n  = idx + N'(1);
                    end
                end else begin
                    wait_n = wait_cnt + 4'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any sweep without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            wait_cnt       <= '0;
            fail_mask      <= '0;
            mismatch_count <= '0;
            pass           <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            operands       <= '0;
            minterm_idx    <= '0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            wait_cnt       <= wait_n;
            fail_mask      <= mask_n;
            mismatch_count <= cnt_n;
            pass           <= pass_n;
            done           <= done_n;
            busy           <= busy_n;
            operands       <= ops_n;
            minterm_idx    <= ops_n;
        end
    end

endmodule

// File: tb/tb_nor_truth_table_sequencer.sv
// Bench for nor_truth_table_sequencer: a default N=2/SETTLE=1 instance driving
// a gate-form or assign-form NOR (or tied outputs), and an N=3/SETTLE=0
// instance driving a 3-input NOR or its inverse. Expected verdicts are queued
// when a sweep is launched and popped when done is observed.
module tb_nor_truth_table_sequencer;

    logic clk = 1'b0;
    // 10-unit clock
    always #5 clk = ~clk;

    logic       reset;
    logic       start2, start3;
    logic [1:0] mode2;
    logic       mode3;

    logic [1:0] operands2, minterm_idx2;
    logic       busy2, done2, pass2;
    logic [3:0] fail_mask2;
    logic [2:0] mismatch_count2;

    logic [2:0] operands3, minterm_idx3;
    logic       busy3, done3, pass3;
    logic [7:0] fail_mask3;
    logic [3:0] mismatch_count3;

    wire  s_gate2;
    wire  s_assign2;
    wire  nor3_s;
    logic dut_s2;
    logic dut_s3;

    // Gate form and assign form of the NOR block under test
    nor g_f5a (s_gate2, operands2[1], operands2[0]);
    assign s_assign2 = ~operands2[1] & ~operands2[0];

    // Select which device drives the N=2 sequencer
    always_comb begin
        dut_s2 = 1'b0;
        case (mode2)
            2'd0:    dut_s2 = s_gate2;
            2'd1:    dut_s2 = s_assign2;
            2'd2:    dut_s2 = 1'b0;
            default: dut_s2 = 1'b1;
        endcase
    end

    nor g_nor3 (nor3_s, operands3[2], operands3[1], operands3[0]);
    assign dut_s3 = mode3 ? ~nor3_s : nor3_s;

    nor_truth_table_sequencer #(.N(2), .EXPECTED(4'b0001), .SETTLE(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .dut_s(dut_s2),
        .operands(operands2), .minterm_idx(minterm_idx2), .busy(busy2),
        .done(done2), .pass(pass2), .fail_mask(fail_mask2),
        .mismatch_count(mismatch_count2)
    );

    nor_truth_table_sequencer #(.N(3), .EXPECTED(8'b0000_0001), .SETTLE(0)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .dut_s(dut_s3),
        .operands(operands3), .minterm_idx(minterm_idx3), .busy(busy3),
        .done(done3), .pass(pass3), .fail_mask(fail_mask3),
        .mismatch_count(mismatch_count3)
    );

    typedef struct {
        logic [31:0] mask;
        logic [31:0] cnt;
        logic [31:0] pass;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic [31:0] o_op, o_idx, o_busy, o_done, o_pass, o_mask, o_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int inst);
        if (inst == 0) begin
            o_op   = 32'(operands2);
            o_idx  = 32'(minterm_idx2);
            o_busy = 32'(busy2);
            o_done = 32'(done2);
            o_pass = 32'(pass2);
            o_mask = 32'(fail_mask2);
            o_cnt  = 32'(mismatch_count2);
        end else begin
            o_op   = 32'(operands3);
            o_idx  = 32'(minterm_idx3);
            o_busy = 32'(busy3);
            o_done = 32'(done3);
            o_pass = 32'(pass3);
            o_mask = 32'(fail_mask3);
            o_cnt  = 32'(mismatch_count3);
        end
    endtask

    task automatic chk_reset_vals(input string who);
        chk({who, "_op"},   o_op,   32'd0);
        chk({who, "_idx"},  o_idx,  32'd0);
        chk({who, "_busy"}, o_busy, 32'd0);
        chk({who, "_done"}, o_done, 32'd0);
        chk({who, "_pass"}, o_pass, 32'd0);
        chk({who, "_mask"}, o_mask, 32'd0);
        chk({who, "_cnt"},  o_cnt,  32'd0);
    endtask

    // Reference verdict: device behaviour per mode scored against a NOR table
    function automatic exp_t model(input int inst, input int mode);
        exp_t       e;
        logic [7:0] ref_tt;
        logic [2:0] kb;
        logic       dv;
        int         n;
        e.mask = '0;
        e.cnt  = '0;
        if (inst == 0) begin
            ref_tt = 8'b0000_0001;
            n = 4;
        end else begin
            ref_tt = 8'b0000_0001;
            n = 8;
        end
        for (int k = 0; k < n; k++) begin
            kb = 3'(k);
            if (inst == 0) begin
                case (mode)
                    0, 1:    dv = ~kb[1] & ~kb[0];
                    2:       dv = 1'b0;
                    default: dv = 1'b1;
                endcase
            end else begin
                dv = ~(kb[2] | kb[1] | kb[0]);
                if (mode != 0) dv = ~dv;
            end
            if (dv != ref_tt[k]) begin
                e.mask[k] = 1'b1;
                e.cnt     = e.cnt + 32'd1;
            end
        end
        e.pass = (e.cnt == 32'd0) ? 32'd1 : 32'd0;
        return e;
    endfunction

    task automatic sweep(input int inst, input int mode, input bit hold);
        int   per;
        int   npts;
        exp_t e;
        per  = (inst == 0) ? 2 : 1;
        npts = (inst == 0) ? 4 : 8;
        if (inst == 0) mode2 = mode[1:0];
        else           mode3 = mode[0];
        sb.push_back(model(inst, mode));
        if (inst == 0) start2 = 1'b1;
        else           start3 = 1'b1;
        tick();
        if (!hold) begin
            start2 = 1'b0;
            start3 = 1'b0;
        end
        for (int j = 0; j < npts * per; j++) begin
            sample(inst);
            chk("run_op",   o_op,   32'(j / per));
            chk("run_idx",  o_idx,  32'(j / per));
            chk("run_busy", o_busy, 32'd1);
            chk("run_done", o_done, 32'd0);
            if (j == 0) begin
                chk("clr_mask", o_mask, 32'd0);
                chk("clr_cnt",  o_cnt,  32'd0);
                chk("clr_pass", o_pass, 32'd0);
            end
            tick();
        end
        sample(inst);
        chk("end_done", o_done, 32'd1);
        chk("end_busy", o_busy, 32'd0);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("end_pass", o_pass, e.pass);
            chk("end_mask", o_mask, e.mask);
            chk("end_cnt",  o_cnt,  e.cnt);
            if (!hold) begin
                tick();
                sample(inst);
                chk("post_done", o_done, 32'd0);
                chk("post_busy", o_busy, 32'd0);
                chk("post_pass", o_pass, e.pass);
                chk("post_mask", o_mask, e.mask);
            end
        end
    endtask

    initial begin
        int found;
        reset  = 1'b1;
        start2 = 1'b1;
        start3 = 1'b1;
        mode2  = 2'd0;
        mode3  = 1'b0;

        // Reset wins over a simultaneous start
        tick();
        tick();
        sample(0);
        chk_reset_vals("rst2");
        sample(1);
        chk_reset_vals("rst3");
        reset  = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        tick();
        sample(0);
        chk("idle_busy", o_busy, 32'd0);

        // Gate form, assign form, tied-0, tied-1
        sweep(0, 0, 1'b0);
        sweep(0, 1, 1'b0);
        sweep(0, 2, 1'b0);
        sweep(0, 3, 1'b0);

        // start held through a whole sweep, then straight into a second one
        sweep(0, 3, 1'b1);
        sweep(0, 0, 1'b0);

        // Reset in the middle of a sweep
        mode2  = 2'd3;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        found  = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            sample(0);
            if (o_idx == 32'd2) found = 1;
            else tick();
        end
        chk("rst_wait", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sample(0);
        chk_reset_vals("midrst");
        for (int k = 0; k < 12; k++) begin
            tick();
            sample(0);
            chk("abort_done", o_done, 32'd0);
            chk("abort_busy", o_busy, 32'd0);
        end
        sweep(0, 0, 1'b0);

        // N=3, SETTLE=0: true NOR then inverted
        sweep(1, 0, 1'b0);
        sweep(1, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
